// File: rtl/queue_key_input.sv
// Button/switch conditioning in front of the queue controller:
// synchronise, debounce, and emit one enq/deq pulse per press.
module key_debounce #(
    parameter int N = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic req
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = PRESSED;
                    req     = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

module queue_key_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_enq,
    input  logic             btn_deq,
    input  logic [WIDTH-1:0] sw,
    output logic             enq,
    output logic             deq,
    output logic [WIDTH-1:0] in
);
    logic [1:0] enq_sync;
    logic [1:0] deq_sync;
    logic [WIDTH-1:0] sw_m;
    logic [WIDTH-1:0] sw_s;
    logic req_e;
    logic req_d;
    logic deq_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            enq_sync <= '0;
            deq_sync <= '0;
            sw_m     <= '0;
            sw_s     <= '0;
        end else begin
            enq_sync <= {enq_sync[0], btn_enq};
            deq_sync <= {deq_sync[0], btn_deq};
            sw_m     <= sw;
            sw_s     <= sw_m;
        end
    end

    key_debounce #(.N(DEBOUNCE_CYCLES)) u_enq (
        .clk (clk),
        .rst (rst),
        .s   (enq_sync[1]),
        .req (req_e)
    );

    key_debounce #(.N(DEBOUNCE_CYCLES)) u_deq (
        .clk (clk),
        .rst (rst),
        .s   (deq_sync[1]),
        .req (req_d)
    );

    // enq wins a collision; the deq is deferred one cycle, never dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            enq         <= 1'b0;
            deq         <= 1'b0;
            deq_pending <= 1'b0;
            in          <= '0;
        end else begin
            enq         <= req_e;
            deq         <= (req_d | deq_pending) & ~req_e;
            deq_pending <= req_e & (req_d | deq_pending);
            if (req_e) begin
                in <= sw_s;
            end
        end
    end
endmodule

// File: doc/queue_key_input.md
# queue_key_input

Input-conditioning stage directly upstream of the queue control unit. Synchronises and debounces the raw enqueue/dequeue push-buttons and the 4-bit data switches, and emits exactly one single-cycle `enq` or `deq` pulse per physical press. Enqueue pulses carry a data word in `in` that is stable in the pulse cycle. Outputs connect directly to the queue controller's `enq`, `deq` and `in` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a press or a release; legal range 1..2^24-1.
- `WIDTH`, default 4: data switch / `in` width.

Ports:
- `clk`  input  1  single system clock, rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `btn_enq`  input  1  raw enqueue button, asynchronous, bouncing.
- `btn_deq`  input  1  raw dequeue button, asynchronous, bouncing.
- `sw`  input  WIDTH  raw data switches, asynchronous.
- `enq`  output  1  registered one-cycle enqueue pulse.
- `deq`  output  1  registered one-cycle dequeue pulse.
- `in`  output  WIDTH  registered data word, valid in every `enq` cycle and held until the next one.

## Operation
- **Synchronisers.** Each of `btn_enq`, `btn_deq` and every `sw` bit passes through a 2-flop synchroniser. The synchronised button is `s`; the synchronised switches are `sw_s`.
- **Per-button FSM.** Each button has its own FSM and its own counter `cnt`, sized to `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit. States:
  - IDLE: if `s`=1, go to PRESS_WAIT with `cnt`=0.
  - PRESS_WAIT:
    - `s`=0: back to IDLE.
    - `s`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to PRESSED and raise the pulse request.
    - Otherwise: `cnt`+1.
  - PRESSED: if `s`=0, go to RELEASE_WAIT with `cnt`=0.
  - RELEASE_WAIT:
    - `s`=1: back to PRESSED, with no new pulse.
    - `s`=0 and `cnt`==DEBOUNCE_CYCLES-1: go to IDLE.
    - Otherwise: `cnt`+1.
- **Pulse generation.** The pulse request is registered, so `enq`/`deq` is high for exactly one cycle per accepted press.
- **Data capture.** On the same edge that sets `enq`=1, `in` <= `sw_s`. `in` is unchanged at all other times, including on `deq` pulses.
- **Arbitration.** `enq` and `deq` are never high in the same cycle.
  - If both requests arise on the same edge, `enq` is issued and a `deq_pending` flag is set.
  - `deq` is issued on the following edge and `deq_pending` is cleared.
  - A pending `deq` is never lost or duplicated.

## Timing
- **Reset values.** On `rst`: both FSMs go to IDLE; `cnt`, synchronisers, `deq_pending`, `enq`, `deq` and `in` all go to 0.
- **Press latency.** Let E0 be the first edge that samples a raw button high, with the button held stable. Then:
  - the synchroniser output `s`=1 after E1;
  - the FSM enters PRESS_WAIT at E2;
  - the pulse is high in the cycle between E(N+2) and E(N+3), where N = DEBOUNCE_CYCLES.
- **Release/re-press spacing.** After release, the button must read low for N consecutive synchronised cycles before a new press is recognised. Two accepted presses of the same button are therefore at least 2N+2 cycles apart.
- **Glitch rejection.**
  - Any low glitch during PRESS_WAIT restarts qualification from IDLE.
  - Any high glitch during RELEASE_WAIT returns the FSM to PRESSED and produces no pulse.
- **Reset mid-operation.** Any state and any pending `deq` are discarded. A button still held after reset is treated as a new press and produces one pulse N+2 edges after `rst` deasserts.
- **Data timing.** `sw` changes are irrelevant except at the capture edge. `sw_s` lags `sw` by 2 edges.
- **Reset interaction.** `rst` has priority over all other activity.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4.)
1. **Clean press.** Reset; `sw`=4'hA; `btn_enq` high from E0 for 20 cycles, then low -> exactly one `enq` pulse, in the cycle after E6, with `in`=4'hA in that cycle; `deq` stays 0.
2. **Press bounce.** `btn_deq` toggles 1,0,1,0 on consecutive cycles, then is held high -> no pulse during bouncing; exactly one `deq` pulse, N+2 edges after the start of the stable high.
3. **Release bounce.** After an accepted press, `btn_enq` goes low for 2 cycles, high for 1, then low -> no second pulse. A new press 5 cycles after the final release does pulse.
4. **Simultaneous press.** `btn_enq` and `btn_deq` rise on the same edge with `sw`=4'h3 -> `enq` pulse with `in`=4'h3, then `deq` in the immediately following cycle; never both high.
5. **Reset mid-qualification.** Assert `rst` in PRESS_WAIT; keep the button held -> no pulse during reset; one pulse 6 edges after `rst` deasserts; all outputs 0 while `rst` is high.
6. **Data hold.** `enq` with `sw`=4'h5, change `sw` to 4'hC, then press `deq` -> `in` stays 4'h5 until the next `enq`, which captures 4'hC.
